// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit imem word writes,
// verifies an 8-bit additive checksum and holds the core in reset until the image is good.
module imem_loader #(
  parameter int unsigned ADDR_W    = 20,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q;
  logic [1:0]         byte_cnt_q;
  logic [23:0]        shift_q;
  logic [IDX_W-1:0]   count_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic [7:0]         sum_q;
  logic               in_ready_q;
  logic               wr_en_q;
  logic [31:0]        wr_addr_q;
  logic [31:0]        wr_data_q;
  logic               cpu_rst_n_q;
  logic               done_q;
  logic               err_q;

  logic               accept;
  logic [23:0]        shift_d;
  logic [31:0]        full_word;
  logic [33:0]        bytes_needed;
  logic               oversize;
  logic [7:0]         sum_d;
  logic               last_word;
  logic [31:0]        word_byte_addr;

  // Header and data words share one shift register; the 4th byte completes it in place.
  always_comb begin
    accept         = in_valid && in_ready_q;
    shift_d        = {in_data, shift_q[23:8]};
    full_word      = {in_data, shift_q};
    bytes_needed   = {2'b00, full_word} << 2;
    oversize       = bytes_needed > (34'd1 << ADDR_W);
    sum_d          = sum_q + in_data;
    last_word      = (word_idx_q == count_q - IDX_W'(1));
    word_byte_addr = BASE_ADDR + (32'(word_idx_q) << 2);
  end

  // NOTE: all state is updated with non-blocking assignments so every branch below
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HDR;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (accept) begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              count_q <= full_word[IDX_W-1:0];
              if (oversize) begin
                state_q    <= S_ERR;
                err_q      <= 1'b1;
                in_ready_q <= 1'b0;
              end else if (full_word == 32'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_q    <= shift_d;
            sum_q      <= sum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= word_byte_addr;
              wr_data_q  <= full_word;
              word_idx_q <= word_idx_q + IDX_W'(1);
              if (last_word) begin
                state_q <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (sum_d == 8'h00) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_q     <= S_HDR;
            byte_cnt_q  <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded word writes plus status checks
// for good, bad, empty, oversize, gappy and reset-interrupted images.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_rst_n, done, err;
  logic [31:0] wr_addr, wr_data;

  logic        s_start, s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_in_ready, s_wr_en, s_cpu_rst_n, s_done, s_err;
  logic [31:0] s_wr_addr, s_wr_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cycle;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img_q[$];
  logic [7:0]  sb_sum;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cycle        = 0;
  int          small_wr_cnt = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(20), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  imem_loader #(.ADDR_W(4), .BASE_ADDR(32'h0)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .cpu_rst_n(s_cpu_rst_n), .done(s_done), .err(s_err)
  );

  always @(posedge clk) cycle++;

  // Write monitor: every wr_en cycle must match the next scoreboard entry exactly.
  always @(negedge clk) begin
    if (s_wr_en) small_wr_cnt++;
    if (wr_en) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_unexpected: got write addr=%h data=%h at cycle %0d, required none",
                 wr_addr, wr_data, cycle);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || cycle != mon_e.cycle) begin
          tests_failed++;
          $display("FAIL wr_word: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   wr_addr, wr_data, cycle, mon_e.addr, mon_e.data, mon_e.cycle);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic s_send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = w[8*i +: 8];
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    s_in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
  endtask

  // Streams header, img_q words and a checksum; pushes one expected write per word.
  task automatic load_image(input int max_gap, input bit good_csum,
                            input logic [7:0] forced_csum, input bit start_mid);
    logic [31:0] hdr;
    logic [31:0] w;
    hdr    = img_q.size();
    sb_sum = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (start_mid && i == 1) start = 1'b1;
      send_byte(hdr[8*i +: 8]);
      start = 1'b0;
    end
    for (int k = 0; k < img_q.size(); k++) begin
      w = img_q[k];
      for (int i = 0; i < 4; i++) begin
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send_byte(w[8*i +: 8]);
        sb_sum = sb_sum + w[8*i +: 8];
      end
      exp_q.push_back('{addr: BASE + 32'(k) * 32'd4, data: w, cycle: cycle});
    end
    if (max_gap > 0) idle($urandom_range(0, max_gap));
    send_byte(good_csum ? (8'h00 - sb_sum) : forced_csum);
  endtask

  task automatic check_status(input string name, input logic [3:0] required);
    tests_run++;
    if ({done, err, cpu_rst_n, in_ready} !== required) begin
      tests_failed++;
      $display("FAIL %s: got {done,err,cpu_rst_n,in_ready}=%b, required %b",
               name, {done, err, cpu_rst_n, in_ready}, required);
    end
  endtask

  task automatic check_drained(input string name);
    idle(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: got %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00;
    idle(3);
    tests_run++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, done, err} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h cpu_rst_n=%b done=%b err=%b, required all 0",
               wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    check_status("reset_release", 4'b0001);
  endtask

  task automatic test_good_image();
    img_q = '{32'h0000_0513, 32'h0010_0593};
    load_image(0, 1'b1, 8'h00, 1'b0);
    check_status("good_done", 4'b1010);
    check_drained("good_writes");
  endtask

  task automatic test_bad_csum();
    pulse_start();
    check_status("rearm_from_done", 4'b0001);
    img_q = '{32'h0000_0513, 32'h0010_0593};
    load_image(0, 1'b0, 8'h00, 1'b0);
    check_status("bad_csum_err", 4'b0100);
    check_drained("bad_csum_writes");
  endtask

  task automatic test_zero_words();
    pulse_start();
    img_q.delete();
    load_image(0, 1'b0, 8'h00, 1'b0);
    check_status("zero_words_good", 4'b1010);
    pulse_start();
    load_image(0, 1'b0, 8'h01, 1'b0);
    check_status("zero_words_bad", 4'b0100);
  endtask

  task automatic test_oversize();
    s_send_word(32'd5);
    tests_run++;
    if ({s_err, s_in_ready, s_done, s_cpu_rst_n} !== 4'b1000 || small_wr_cnt != 0) begin
      tests_failed++;
      $display("FAIL oversize_w5: got {err,in_ready,done,cpu_rst_n}=%b writes=%0d, required 1000 writes=0",
               {s_err, s_in_ready, s_done, s_cpu_rst_n}, small_wr_cnt);
    end
    s_pulse_start();
    s_send_word(32'h4000_0001);
    tests_run++;
    if ({s_err, s_in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL oversize_nowrap: got {err,in_ready}=%b, required 10", {s_err, s_in_ready});
    end
    s_pulse_start();
    s_send_word(32'd4);
    tests_run++;
    if ({s_err, s_in_ready, small_wr_cnt == 0} !== 3'b011) begin
      tests_failed++;
      $display("FAIL capacity_exact: got {err,in_ready}=%b writes=%0d, required 01 writes=0",
               {s_err, s_in_ready}, small_wr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    img_q.delete();
    for (int k = 0; k < 3; k++) img_q.push_back($urandom);
    load_image(0, 1'b1, 8'h00, 1'b0);
    check_status("b2b_done", 4'b1010);
    check_drained("b2b_writes");
    pulse_start();
    load_image(3, 1'b1, 8'h00, 1'b1);
    check_status("gaps_done", 4'b1010);
    check_drained("gaps_writes");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h02 : 8'h00);
    send_byte(8'h55);
    send_byte(8'hAA);
    rst = 1'b0;
    #2;
    tests_run++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, done, err} !== 67'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got wr_en=%b addr=%h data=%h cpu_rst_n=%b done=%b err=%b, required all 0",
               wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
    end
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    check_status("mid_reset_release", 4'b0001);
    pulse_start();
    img_q = '{32'hCAFE_0137};
    load_image(0, 1'b1, 8'h00, 1'b0);
    check_status("after_reset_done", 4'b1010);
    check_drained("after_reset_writes");
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_csum();
    test_zero_words();
    test_oversize();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
